// File: rtl/colorspace_frame_controller.sv
// Frame sequencer for the RGB->gray converter: paces intake on a pixel tick and tracks pipeline occupancy.
// Results appear CONV_LATENCY advances after load; a stalled tail freezes every advance, so no pixel is dropped.
module colorspace_frame_controller #(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int CONV_LATENCY = 3,
  parameter int PIXEL_DIV    = 4,
  localparam int COL_W = $clog2(IMAGE_WIDTH),
  localparam int ROW_W = $clog2(IMAGE_HEIGHT)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic             in_ready,
  output logic             conv_load,
  output logic             conv_advance,
  output logic             conv_clear,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [COL_W-1:0] out_col,
  output logic [ROW_W-1:0] out_row,
  output logic             out_eol,
  output logic             out_eof,
  output logic             frame_done,
  output logic             sof_error
);

  localparam int DIV_W     = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;
  localparam int PIX_TOTAL = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int CNT_W     = $clog2(PIX_TOTAL + 1);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [CONV_LATENCY-1:0] occ_q, occ_d;
  logic [CNT_W-1:0]        in_count_q, in_count_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [ROW_W-1:0]        row_q, row_d;

  logic run, tick, tail_valid, stall, xfer, accept;

  // Reset also masks outputs so nothing leaks while state is being cleared.
  assign run          = enable && !reset;
  assign tick         = (div_q == DIV_W'(PIXEL_DIV - 1));
  assign tail_valid   = occ_q[CONV_LATENCY-1];
  assign stall        = tail_valid && !out_ready;
  assign conv_advance = run && tick && !stall;
  assign out_valid    = tail_valid && run && tick;
  assign xfer         = out_valid && out_ready;
  assign in_ready     = conv_advance && ((state_q == WAIT_SOF) || (state_q == ACTIVE));
  assign accept       = in_valid && in_ready;
  assign out_col      = col_q;
  assign out_row      = row_q;
  assign out_eol      = out_valid && (col_q == COL_W'(IMAGE_WIDTH - 1));
  assign out_eof      = out_eol && (row_q == ROW_W'(IMAGE_HEIGHT - 1));

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    occ_d      = occ_q;
    in_count_d = in_count_q;
    col_d      = col_q;
    row_d      = row_q;
    conv_load  = 1'b0;
    conv_clear = 1'b0;
    frame_done = 1'b0;
    sof_error  = 1'b0;

    if (run) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    if (xfer) begin
      if (col_q == COL_W'(IMAGE_WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(IMAGE_HEIGHT - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (run) begin
          state_d    = WAIT_SOF;
          conv_clear = 1'b1;
        end
      end
      WAIT_SOF: begin
        // Pixels ahead of start-of-frame are consumed and thrown away.
        if (accept && in_sof) begin
          conv_load  = 1'b1;
          in_count_d = CNT_W'(1);
          state_d    = ACTIVE;
        end
      end
      ACTIVE: begin
        if (accept) begin
          conv_load  = 1'b1;
          in_count_d = in_count_q + CNT_W'(1);
          sof_error  = in_sof;
          if (in_count_q == CNT_W'(PIX_TOTAL - 1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (xfer && out_eof) begin
          state_d    = WAIT_SOF;
          frame_done = 1'b1;
          conv_clear = 1'b1;
          in_count_d = '0;
          col_d      = '0;
          row_d      = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (conv_advance) begin
      occ_d[0] = conv_load;
      for (int i = 1; i < CONV_LATENCY; i++) begin
        occ_d[i] = occ_q[i-1];
      end
    end
    if (conv_clear) begin
      occ_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      occ_q      <= '0;
      in_count_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      occ_q      <= occ_d;
      in_count_q <= in_count_d;
      col_q      <= col_d;
      row_q      <= row_d;
    end
  end

endmodule
